machine_ctrl: RTL and testbench
===============================

MACHINE_CTRL -- requirements
Module: machine_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 Port clk  input  1: single clock; all state updates on rising edge.
REQ-003 Port rst  input  1: asynchronous, active-high reset.
REQ-004 Port ena  input  1: run enable; sampled only in IDLE and S7.
REQ-005 Port opcode  input  3: instruction opcode from the IR. HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
REQ-006 Port zero  input  1: accumulator-zero flag.
REQ-007 Port resume  input  1: leave HALT.
REQ-008 Outputs, each 1 bit: rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt, busy.
REQ-009 Port retire_cnt  output  CNT_W: count of completed instructions.

Function
REQ-010 States: IDLE, S0-S7 and HALT, held in one state register; each of S0-S7 lasts exactly one cycle.
REQ-011 Control outputs are a combinational decode of state, latched opcode op_q and latched zero z_q; every output not listed for a state is 0.
REQ-012 In IDLE, all control outputs are 0 and busy=0. With ena=1 the next state is S0; otherwise IDLE holds.
REQ-013 S0: rd=1, load_ir=1 (high instruction byte).
REQ-014 S1: rd=1, load_ir=1, inc_pc=1 (low instruction byte).
REQ-015 S2: all control outputs 0; at the end of S2, op_q<=opcode and z_q<=zero.
REQ-016 S3: inc_pc=1.
REQ-017 S3 transition: if op_q==HLT, the next state is HALT; otherwise the next state is S4.
REQ-018 S4:
- ADD/AND/XOR/LDA: rd=1.
- STO: datactl_ena=1.
- JMP: load_pc=1.
- SKZ with z_q=1: inc_pc=1.
REQ-019 S5:
- ADD/AND/XOR/LDA: rd=1, load_acc=1.
- STO: datactl_ena=1, wr=1.
- JMP: load_pc=1.
- SKZ with z_q=1: inc_pc=1.
REQ-020 S6: STO: datactl_ena=1; all other opcodes output 0.
REQ-021 S7: all control outputs 0; retire_cnt increments by 1. The next state is S0 if ena=1, else IDLE.
REQ-022 SKZ with z_q=0 produces no pulse in S4-S5; the PC advances exactly 2 per instruction.
REQ-023 SKZ with z_q=1 skips the next 2-byte instruction, giving 4 inc_pc pulses in total.
REQ-024 wr is asserted only in S5, and only for STO; datactl_ena brackets it (S4-S6).
REQ-025 load_pc and inc_pc are never asserted in the same cycle.
REQ-026 HALT: halt=1 and all other control outputs 0. If resume=1, the next state is S0; otherwise HALT holds. ena is ignored in HALT.
REQ-027 HLT retires: retire_cnt increments on the S3->HALT transition.
REQ-028 retire_cnt wraps from 2^CNT_W-1 to 0 with no flag.
REQ-029 busy=1 in S0-S7, and 0 in IDLE and HALT.
REQ-030 ena deasserted during S0-S6 has no effect; the instruction completes through S7.
REQ-031 opcode and zero changes outside S2 do not alter the decode of the current instruction.

Reset
REQ-032 rst=1 forces, immediately and asynchronously: state=IDLE, op_q=000, z_q=0, retire_cnt=0. All control outputs, halt and busy read 0.
REQ-033 rst overrides all other inputs, including mid-instruction (any of S0-S7) and in HALT.
REQ-034 On the first rising edge after rst falls, the block evaluates from IDLE.

Verification
REQ-035 Reset, then ena=1, opcode=LDA:
- S0-S1: rd=1, load_ir=1; inc_pc in S1.
- inc_pc in S3.
- S4: rd=1; S5: rd=1, load_acc=1.
- retire_cnt=1 after S7.
REQ-036 STO: datactl_ena=1 in S4, S5 and S6; wr=1 only in S5; rd=0 in S4-S7.
REQ-037 SKZ, zero=1 at S2:
- 4 inc_pc pulses per instruction (S1, S3, S4, S5).
- With zero=0 at S2: exactly 2 pulses.
REQ-038 JMP: load_pc=1 in S4-S5 with inc_pc=0 in those cycles; back-to-back instructions when ena stays 1 (S7->S0).
REQ-039 HLT: HALT entered after S3 and halt=1 held 10 cycles with resume=0; resume=1 -> S0 next cycle; retire_cnt incremented once.
REQ-040 Boundaries:
- rst=1 asserted in S5 -> outputs 0 and state IDLE without a clock edge.
- ena dropped in S2 -> instruction completes, then IDLE.
- retire_cnt preloaded to 0xFFFF by running -> wraps to 0x0000.

Source files
------------

// File: rtl/machine_ctrl.sv
// machine_ctrl: multi-cycle instruction sequencer for an 8-bit accumulator CPU.
// Fetches a 2-byte instruction in S0-S1, latches opcode/zero in S2, executes in S3-S7.
module machine_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             resume,
  output logic             rd,
  output logic             wr,
  output logic             load_ir,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             load_acc,
  output logic             datactl_ena,
  output logic             halt,
  output logic             busy,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [3:0] {
    IDLE, S0, S1, S2, S3, S4, S5, S6, S7, HALT
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  state_t     state_nx;
  logic [2:0] op_q;
  logic       z_q;
  logic       is_mem;
  logic       is_sto;
  logic       is_jmp;
  logic       is_skip;
  logic       retire;

  assign is_mem  = (op_q == OP_ADD) || (op_q == OP_AND) ||
                   (op_q == OP_XOR) || (op_q == OP_LDA);
  assign is_sto  = (op_q == OP_STO);
  assign is_jmp  = (op_q == OP_JMP);
  assign is_skip = (op_q == OP_SKZ) && z_q;
  assign retire  = (state == S7) ||
                   ((state == S3) && (op_q == OP_HLT));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Capture the instruction decode inputs once, at the end of S2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= OP_HLT;
      z_q  <= 1'b0;
    end else if (state == S2) begin
      op_q <= opcode;
      z_q  <= zero;
    end
  end

  // Retired-instruction counter, free-running wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + CNT_ONE;
  end

  // Next-state and control decode
  always_comb begin
    state_nx    = state;
    rd          = 1'b0;
    wr          = 1'b0;
    load_ir     = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    busy        = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (ena) state_nx = S0;
      end
      S0: begin
        rd       = 1'b1;
        load_ir  = 1'b1;
        state_nx = S1;
      end
      S1: begin
        rd       = 1'b1;
        load_ir  = 1'b1;
        inc_pc   = 1'b1;
        state_nx = S2;
      end
      S2: state_nx = S3;
      S3: begin
        inc_pc   = 1'b1;
        state_nx = (op_q == OP_HLT) ? HALT : S4;
      end
      S4: begin
        rd          = is_mem;
        datactl_ena = is_sto;
        load_pc     = is_jmp;
        inc_pc      = is_skip;
        state_nx    = S5;
      end
      S5: begin
        rd          = is_mem;
        load_acc    = is_mem;
        datactl_ena = is_sto;
        wr          = is_sto;
        load_pc     = is_jmp;
        inc_pc      = is_skip;
        state_nx    = S6;
      end
      S6: begin
        datactl_ena = is_sto;
        state_nx    = S7;
      end
      S7: state_nx = ena ? S0 : IDLE;
      HALT: begin
        busy = 1'b0;
        halt = 1'b1;
        if (resume) state_nx = S0;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_machine_ctrl.sv
// tb_machine_ctrl: scoreboard bench for machine_ctrl.
// Stimulus queues per-cycle expected outputs; a negedge monitor pops and compares.
module tb_machine_ctrl;

  // Narrow counter so the wrap boundary is reachable in a short run
  localparam int CNT_W = 4;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  // {rd,wr,load_ir,inc_pc,load_pc,load_acc,datactl_ena,halt,busy}
  localparam logic [8:0] V_S0   = 9'b101000001;
  localparam logic [8:0] V_S1   = 9'b101100001;
  localparam logic [8:0] V_NOP  = 9'b000000001;
  localparam logic [8:0] V_S3   = 9'b000100001;
  localparam logic [8:0] V_RD   = 9'b100000001;
  localparam logic [8:0] V_RDLA = 9'b100001001;
  localparam logic [8:0] V_DC   = 9'b000000101;
  localparam logic [8:0] V_WR   = 9'b010000101;
  localparam logic [8:0] V_JMP  = 9'b000010001;
  localparam logic [8:0] V_INC  = 9'b000100001;
  localparam logic [8:0] V_HALT = 9'b000000010;
  localparam logic [8:0] V_ZERO = 9'b000000000;

  typedef struct packed {
    logic [8:0]       v;
    logic [CNT_W-1:0] c;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             ena;
  logic [2:0]       opcode;
  logic             zero;
  logic             resume;
  logic             rd;
  logic             wr;
  logic             load_ir;
  logic             inc_pc;
  logic             load_pc;
  logic             load_acc;
  logic             datactl_ena;
  logic             halt;
  logic             busy;
  logic [CNT_W-1:0] retire_cnt;
  logic [8:0]       obs;

  exp_t             q[$];
  logic [CNT_W-1:0] exp_cnt;
  int               n_chk;
  int               n_fail;

  machine_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .opcode      (opcode),
    .zero        (zero),
    .resume      (resume),
    .rd          (rd),
    .wr          (wr),
    .load_ir     (load_ir),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_acc    (load_acc),
    .datactl_ena (datactl_ena),
    .halt        (halt),
    .busy        (busy),
    .retire_cnt  (retire_cnt)
  );

  assign obs = {rd, wr, load_ir, inc_pc, load_pc,
                load_acc, datactl_ena, halt, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT is active, pop and compare one entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (busy || halt)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_activity: got %b expected idle at %0t",
                 obs, $time);
      end else begin
        e = q.pop_front();
        chk("ctrl_vec", {23'd0, obs}, {23'd0, e.v});
        chk("retire_cnt", {28'd0, retire_cnt}, {28'd0, e.c});
      end
    end
  end

  task automatic push(input logic [8:0] v);
    exp_t e;
    e.v = v;
    e.c = exp_cnt;
    q.push_back(e);
  endtask

  // One full instruction; entry state is IDLE/S7/HALT(resume), exit in S7
  task automatic run(input logic [2:0] op, input logic z,
                     input bit drop_s2, input bit scramble);
    logic [8:0] s4, s5, s6;
    s4 = V_NOP;
    s5 = V_NOP;
    s6 = V_NOP;
    case (op)
      ADD, AND, XOR, LDA: begin s4 = V_RD;  s5 = V_RDLA; end
      STO: begin s4 = V_DC; s5 = V_WR; s6 = V_DC; end
      JMP: begin s4 = V_JMP; s5 = V_JMP; end
      SKZ: if (z) begin s4 = V_INC; s5 = V_INC; end
      default: ;
    endcase
    push(V_S0);
    push(V_S1);
    push(V_NOP);
    push(V_S3);
    push(s4);
    push(s5);
    push(s6);
    push(V_NOP);
    exp_cnt = exp_cnt + 1'b1;
    opcode = op;
    zero   = z;
    ena    = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) resume = 1'b0;
      if (k == 3 && drop_s2) ena = 1'b0;
      if (k == 4 && scramble) begin
        opcode = ~op;
        zero   = ~z;
      end
    end
  endtask

  task automatic idle_chk(input string name);
    ena = 1'b0;
    @(posedge clk);
    #1;
    chk(name, {23'd0, obs}, {23'd0, V_ZERO});
    chk({name, "_cnt"}, {28'd0, retire_cnt}, {28'd0, exp_cnt});
  endtask

  task automatic run_hlt();
    push(V_S0);
    push(V_S1);
    push(V_NOP);
    push(V_S3);
    exp_cnt = exp_cnt + 1'b1;
    for (int k = 0; k < 10; k++) push(V_HALT);
    opcode = HLT;
    zero   = 1'b0;
    ena    = 1'b1;
    resume = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] ops [7];
    ops = '{ADD, AND, XOR, LDA, STO, JMP, SKZ};
    n_chk   = 0;
    n_fail  = 0;
    exp_cnt = '0;
    rst     = 1'b1;
    ena     = 1'b0;
    opcode  = HLT;
    zero    = 1'b0;
    resume  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {23'd0, obs}, {23'd0, V_ZERO});
    chk("reset_cnt", {28'd0, retire_cnt}, 32'd0);
    rst = 1'b0;
    idle_chk("idle_hold");
    idle_chk("idle_hold2");

    run(LDA, 1'b0, 1'b0, 1'b0);
    idle_chk("after_lda");

    run(STO, 1'b0, 1'b0, 1'b0);
    run(ADD, 1'b1, 1'b0, 1'b0);
    run(AND, 1'b0, 1'b0, 1'b0);
    run(XOR, 1'b0, 1'b0, 1'b0);
    run(JMP, 1'b0, 1'b0, 1'b0);
    run(SKZ, 1'b1, 1'b0, 1'b0);
    run(SKZ, 1'b0, 1'b0, 1'b1);
    run(STO, 1'b1, 1'b0, 1'b1);
    run(SKZ, 1'b1, 1'b1, 1'b0);
    idle_chk("after_drop_s2");

    run_hlt();
    resume = 1'b1;
    run(LDA, 1'b0, 1'b0, 1'b0);
    idle_chk("after_resume");

    push(V_S0);
    push(V_S1);
    push(V_NOP);
    push(V_S3);
    push(V_RD);
    opcode = LDA;
    ena    = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("async_rst_out", {23'd0, obs}, {23'd0, V_ZERO});
    chk("async_rst_cnt", {28'd0, retire_cnt}, 32'd0);
    exp_cnt = '0;
    ena     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_chk("post_rst_idle");

    for (int i = 0; i < 16; i++)
      run(ops[i % 7], i[0], 1'b0, 1'b0);
    idle_chk("wrap_idle");
    chk("wrap_zero", {28'd0, retire_cnt}, 32'd0);

    repeat (2) @(posedge clk);
    chk("queue_drain", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
